loop_addr_gen: RTL and testbench

LOOP_ADDR_GEN -- requirements
Module: loop_addr_gen

---
 rtl/loop_addr_gen.sv | 139 +++++++++++++
 tb/tb_loop_addr_gen.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/loop_addr_gen.sv
// Address generator slaved to a nested-loop controller: per-loop strides and offset stack.
// Optional bounds checking is enabled by defining LOOP_ADDR_GEN_OOB_CHECK_EN.
module loop_addr_gen #(
  parameter int LOOP_ID_W = 5,
  parameter int ADDR_W    = 32,
  parameter int STRIDE_W  = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic                 cfg_stride_v,
  input  logic [LOOP_ID_W-1:0] cfg_stride_loop_id,
  input  logic [STRIDE_W-1:0]  cfg_stride,
  input  logic                 stall,
  input  logic [LOOP_ID_W-1:0] loop_index,
  input  logic                 loop_index_valid,
  input  logic                 loop_init,
  input  logic                 loop_enter,
  input  logic                 loop_exit,
  input  logic                 loop_last_iter,
  input  logic                 loop_done,
  input  logic [ADDR_W-1:0]    addr_limit,
  output logic [ADDR_W-1:0]    addr_out,
  output logic                 addr_out_v,
  output logic                 addr_done,
  output logic                 addr_oob
);

  localparam int DEPTH = 1 << LOOP_ID_W;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t state, state_nxt;

  logic [DEPTH-1:0][STRIDE_W-1:0] stride_tbl;
  logic [DEPTH-1:0][ADDR_W-1:0]   stack;
  logic [ADDR_W-1:0]              cur_addr;
  logic [ADDR_W-1:0]              cur_nxt;
  logic [ADDR_W-1:0]              stride_ext;
  logic [ADDR_W-1:0]              exit_addr;
  logic [ADDR_W-1:0]              stack_wdata;
  logic                           stack_we;
  logic                           step;

  assign stride_ext = {{(ADDR_W-STRIDE_W){stride_tbl[loop_index][STRIDE_W-1]}},
                       stride_tbl[loop_index]};
  assign exit_addr  = stack[loop_index] + stride_ext;

  // A restart swallows any coincident step; nothing is emitted until a stream is initialised.
  assign step = (state == S_RUN) && loop_index_valid && !stall && !loop_init;

  always_comb begin
    // NOTE: every signal gets a default first so no path through this block infers a latch.
    state_nxt = state;
    case (state)
      S_IDLE:  if (loop_init) state_nxt = S_RUN;
      S_RUN:   if (!loop_init && loop_done) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cur_nxt     = cur_addr;
    stack_we    = 1'b0;
    stack_wdata = cur_addr;
    if (loop_init) begin
      cur_nxt     = base_addr;
      stack_we    = 1'b1;
      stack_wdata = base_addr;
    end else begin
      if (loop_enter) begin
        stack_we    = 1'b1;
        stack_wdata = cur_addr;
      end
      if (loop_exit && !loop_last_iter) begin
        stack_we    = 1'b1;
        stack_wdata = exit_addr;
        cur_nxt     = exit_addr;
      end else if (step && !loop_last_iter) begin
        cur_nxt = cur_addr + stride_ext;
      end
    end
  end

  // NOTE: the tables are reset because a stride left unwritten must read as zero, not X;
  // packed storage keeps that reset a single whole-vector clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stride_tbl <= '0;
    end else if (cfg_stride_v) begin
      stride_tbl[cfg_stride_loop_id] <= cfg_stride;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stack <= '0;
    end else if (stack_we) begin
      stack[loop_index] <= stack_wdata;
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      cur_addr   <= '0;
      addr_out   <= '0;
      addr_out_v <= 1'b0;
      addr_done  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cur_addr   <= cur_nxt;
      addr_out_v <= step;
      addr_done  <= loop_done && (state == S_RUN);
      if (step) addr_out <= cur_addr;
    end
  end

`ifdef LOOP_ADDR_GEN_OOB_CHECK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_oob <= 1'b0;
    end else if (loop_init) begin
      addr_oob <= 1'b0;
    end else if (step && (cur_addr >= addr_limit)) begin
      addr_oob <= 1'b1;
    end
  end
`else
  logic unused_addr_limit;
  assign unused_addr_limit = ^addr_limit;
  assign addr_oob          = 1'b0;
`endif

endmodule

// File: tb/tb_loop_addr_gen.sv
// Directed bench for loop_addr_gen: single/nested loops, stall, wrap, restart, async reset.
module tb_loop_addr_gen;

  localparam int LOOP_ID_W = 5;
  localparam int ADDR_W    = 32;
  localparam int STRIDE_W  = 16;
`ifdef LOOP_ADDR_GEN_OOB_CHECK_EN
  localparam bit OOB_EN = 1'b1;
`else
  localparam bit OOB_EN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [ADDR_W-1:0]    base_addr;
  logic                 cfg_stride_v;
  logic [LOOP_ID_W-1:0] cfg_stride_loop_id;
  logic [STRIDE_W-1:0]  cfg_stride;
  logic                 stall;
  logic [LOOP_ID_W-1:0] loop_index;
  logic                 loop_index_valid;
  logic                 loop_init;
  logic                 loop_enter;
  logic                 loop_exit;
  logic                 loop_last_iter;
  logic                 loop_done;
  logic [ADDR_W-1:0]    addr_limit;
  logic [ADDR_W-1:0]    addr_out;
  logic                 addr_out_v;
  logic                 addr_done;
  logic                 addr_oob;

  int n_cmp = 0;
  int n_err = 0;

  loop_addr_gen #(
    .LOOP_ID_W(LOOP_ID_W),
    .ADDR_W   (ADDR_W),
    .STRIDE_W (STRIDE_W)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .base_addr         (base_addr),
    .cfg_stride_v      (cfg_stride_v),
    .cfg_stride_loop_id(cfg_stride_loop_id),
    .cfg_stride        (cfg_stride),
    .stall             (stall),
    .loop_index        (loop_index),
    .loop_index_valid  (loop_index_valid),
    .loop_init         (loop_init),
    .loop_enter        (loop_enter),
    .loop_exit         (loop_exit),
    .loop_last_iter    (loop_last_iter),
    .loop_done         (loop_done),
    .addr_limit        (addr_limit),
    .addr_out          (addr_out),
    .addr_out_v        (addr_out_v),
    .addr_done         (addr_done),
    .addr_oob          (addr_oob)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [31:0] a, input logic d);
    check({tag, "_v"}, {31'd0, addr_out_v}, {31'd0, v});
    check({tag, "_addr"}, addr_out, a);
    check({tag, "_done"}, {31'd0, addr_done}, {31'd0, d});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_ctl();
    cfg_stride_v     = 1'b0;
    stall            = 1'b0;
    loop_index_valid = 1'b0;
    loop_init        = 1'b0;
    loop_enter       = 1'b0;
    loop_exit        = 1'b0;
    loop_last_iter   = 1'b0;
    loop_done        = 1'b0;
  endtask

  task automatic set_stride(input logic [LOOP_ID_W-1:0] id, input logic [STRIDE_W-1:0] s);
    cfg_stride_v       = 1'b1;
    cfg_stride_loop_id = id;
    cfg_stride         = s;
    tick();
    cfg_stride_v       = 1'b0;
  endtask

  task automatic init(input logic [ADDR_W-1:0] base, input logic [LOOP_ID_W-1:0] idx);
    base_addr  = base;
    loop_index = idx;
    loop_init  = 1'b1;
    loop_enter = 1'b1;
    tick();
    clr_ctl();
  endtask

  task automatic enter(input logic [LOOP_ID_W-1:0] idx);
    loop_index = idx;
    loop_enter = 1'b1;
    tick();
    clr_ctl();
  endtask

  task automatic exit_loop(input logic [LOOP_ID_W-1:0] idx, input logic last, input logic stl);
    loop_index     = idx;
    loop_exit      = 1'b1;
    loop_last_iter = last;
    stall          = stl;
    tick();
    clr_ctl();
  endtask

  task automatic step(input logic [LOOP_ID_W-1:0] idx, input logic last, input logic done);
    loop_index       = idx;
    loop_index_valid = 1'b1;
    loop_last_iter   = last;
    loop_done        = done;
    tick();
    clr_ctl();
  endtask

  initial begin
    logic [31:0] a;
    reset_n            = 1'b0;
    base_addr          = '0;
    cfg_stride_loop_id = '0;
    cfg_stride         = '0;
    loop_index         = '0;
    addr_limit         = '1;
    clr_ctl();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_out("rst", 1'b0, 32'h0, 1'b0);
    check("rst_oob", {31'd0, addr_oob}, 32'h0);
    #2 reset_n = 1'b1;
    tick();

    // Single loop, stride 4, 4 iterations; bounds limit at 0x1008
    set_stride(0, 16'd4);
    addr_limit = 32'h0000_1008;
    init(32'h1000, 0);
    check_out("t1_init", 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      a = 32'h1000 + 32'(4 * i);
      step(0, i == 3, i == 3);
      check_out($sformatf("t1_step%0d", i), 1'b1, a, i == 3);
      check($sformatf("t1_oob%0d", i), {31'd0, addr_oob}, {31'd0, OOB_EN && (a >= 32'h1008)});
    end
    tick();
    check_out("t1_idle", 1'b0, 32'h100C, 1'b0);
    check("t1_oob_sticky", {31'd0, addr_oob}, {31'd0, OOB_EN});
    addr_limit = '1;

    // Stride rewritten in the cycle of a step: that step still uses the old stride
    init(32'h2000, 0);
    check("t2_oob_clr", {31'd0, addr_oob}, 32'h0);
    loop_index         = 0;
    loop_index_valid   = 1'b1;
    cfg_stride_v       = 1'b1;
    cfg_stride_loop_id = 0;
    cfg_stride         = 16'd8;
    tick();
    clr_ctl();
    check_out("t2_s0", 1'b1, 32'h2000, 1'b0);
    step(0, 1'b0, 1'b0);
    check_out("t2_s1", 1'b1, 32'h2004, 1'b0);
    step(0, 1'b1, 1'b1);
    check_out("t2_s2", 1'b1, 32'h200C, 1'b1);

    // Stall for 3 cycles at the second step
    set_stride(0, 16'd4);
    init(32'h1000, 0);
    step(0, 1'b0, 1'b0);
    check_out("t3_s0", 1'b1, 32'h1000, 1'b0);
    loop_index       = 0;
    loop_index_valid = 1'b1;
    stall            = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out($sformatf("t3_stall%0d", i), 1'b0, 32'h1000, 1'b0);
    end
    clr_ctl();
    for (int i = 1; i < 4; i++) begin
      step(0, i == 3, i == 3);
      check_out($sformatf("t3_s%0d", i), 1'b1, 32'h1000 + 32'(4 * i), i == 3);
    end

    // Two nested loops: outer index 1 (stride 0x100), inner index 0 (stride 1)
    set_stride(0, 16'h0001);
    set_stride(1, 16'h0100);
    init(32'h0, 1);
    enter(0);
    check_out("t4_enter", 1'b0, 32'h100C, 1'b0);
    step(0, 1'b0, 1'b0);
    check_out("t4_a0", 1'b1, 32'h0, 1'b0);
    step(0, 1'b1, 1'b0);
    check_out("t4_a1", 1'b1, 32'h1, 1'b0);
    exit_loop(0, 1'b1, 1'b0);
    check_out("t4_exit0", 1'b0, 32'h1, 1'b0);
    exit_loop(1, 1'b0, 1'b1);
    enter(0);
    step(0, 1'b0, 1'b0);
    check_out("t4_a2", 1'b1, 32'h100, 1'b0);
    step(0, 1'b1, 1'b1);
    check_out("t4_a3", 1'b1, 32'h101, 1'b1);
    exit_loop(0, 1'b1, 1'b0);
    exit_loop(1, 1'b1, 1'b0);
    check_out("t4_end", 1'b0, 32'h101, 1'b0);

    // Negative strides with restart mid-stream, then wrap below zero
    set_stride(0, 16'hFFFC);
    init(32'h10, 0);
    step(0, 1'b0, 1'b0);
    check_out("t5_pre", 1'b1, 32'h10, 1'b0);
    init(32'h10, 0);
    check_out("t5_restart", 1'b0, 32'h10, 1'b0);
    step(0, 1'b0, 1'b0);
    check_out("t5_s0", 1'b1, 32'h10, 1'b0);
    step(0, 1'b0, 1'b0);
    check_out("t5_s1", 1'b1, 32'h0C, 1'b0);
    step(0, 1'b1, 1'b1);
    check_out("t5_s2", 1'b1, 32'h08, 1'b1);
    set_stride(0, 16'hFFF8);
    init(32'h4, 0);
    step(0, 1'b0, 1'b0);
    check_out("t5_w0", 1'b1, 32'h4, 1'b0);
    step(0, 1'b1, 1'b1);
    check_out("t5_w1", 1'b1, 32'hFFFF_FFFC, 1'b1);

    // Asynchronous reset during the second step
    set_stride(0, 16'd4);
    init(32'h1000, 0);
    step(0, 1'b0, 1'b0);
    check_out("t6_s0", 1'b1, 32'h1000, 1'b0);
    loop_index       = 0;
    loop_index_valid = 1'b1;
    #3 reset_n = 1'b0;
    #1;
    check_out("t6_async", 1'b0, 32'h0, 1'b0);
    #2 reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out($sformatf("t6_post%0d", i), 1'b0, 32'h0, 1'b0);
    end
    clr_ctl();
    // Strides were cleared by reset, so the address does not advance
    init(32'h3000, 0);
    step(0, 1'b0, 1'b0);
    check_out("t6_r0", 1'b1, 32'h3000, 1'b0);
    step(0, 1'b1, 1'b1);
    check_out("t6_r1", 1'b1, 32'h3000, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
